// File: rtl/sh7604_prescaler.sv
// Free-running 13-bit clock-enable prescaler feeding the SH7604 WDT, FRT and SCI blocks.
// Optional build macro SH7604_PRESC_SBY_RESTART_EN: restart the count on standby exit.
module sh7604_prescaler #(
    parameter bit DISABLE      = 1'b0,
    parameter bit PER_SBY_GATE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_r,
    input  logic        en,
    input  logic        res_n,
    input  logic        sby,
    output logic [7:0]  wdt_ce,
    output logic [5:0]  per_ce,
    output logic [12:0] div_cnt
);

    logic [12:0] div_q;
    logic [12:0] div_d;
    logic        sby_dly_q;
    logic        sby_dly_d;
    logic        tick;
    logic        restart;
    logic        strobe_en;
    logic        per_gate;
    logic [12:0] ones;
    logic        unused_ones;

    assign tick = en & ce_r & ~DISABLE & res_n;

    // ones[gi] is set when the low gi+1 bits are all ones: the 1/2^(gi+1) strobe point
    for (genvar gi = 0; gi < 13; gi++) begin : g_ones
        assign ones[gi] = &div_q[gi:0];
    end

    assign unused_ones = ones[10];

`ifdef SH7604_PRESC_SBY_RESTART_EN
    assign restart = tick & sby_dly_q & ~sby;
`else
    logic unused_sby_dly;
    assign restart        = 1'b0;
    assign unused_sby_dly = sby_dly_q;
`endif

    always_comb begin
        div_d     = div_q;
        sby_dly_d = sby_dly_q;
        if (!res_n) begin
            div_d     = 13'd0;
            sby_dly_d = 1'b0;
        end else if (tick) begin
            div_d     = restart ? 13'd0 : div_q + 13'd1;
            sby_dly_d = sby;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= 13'd0;
            sby_dly_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            sby_dly_q <= sby_dly_d;
        end
    end

    assign strobe_en = tick & ~restart;
    assign per_gate  = PER_SBY_GATE & sby;

    assign wdt_ce = {8{strobe_en}} &
                    {ones[12], ones[11], ones[9], ones[8], ones[7], ones[6], ones[5], ones[0]};
    assign per_ce = {6{strobe_en & ~per_gate}} &
                    {ones[6], ones[5], ones[4], ones[3], ones[2], ones[1]};
    assign div_cnt = div_q;

endmodule

// File: tb/tb_sh7604_prescaler.sv
// Directed bench for sh7604_prescaler: arithmetic reference model with a strobe/count scoreboard.
module tb_sh7604_prescaler;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_r;
    logic        en;
    logic        res_n;
    logic        sby;
    logic [7:0]  wdt_ce;
    logic [5:0]  per_ce;
    logic [12:0] div_cnt;

    sh7604_prescaler dut (
        .clk     (clk),
        .rst     (rst),
        .ce_r    (ce_r),
        .en      (en),
        .res_n   (res_n),
        .sby     (sby),
        .wdt_ce  (wdt_ce),
        .per_ce  (per_ce),
        .div_cnt (div_cnt)
    );

    always #5 clk = ~clk;

    localparam int WDT_DIV [8] = '{2, 64, 128, 256, 512, 1024, 4096, 8192};
    localparam int PER_DIV [6] = '{4, 8, 16, 32, 64, 128};

    typedef struct packed {
        logic [7:0] wdt;
        logic [5:0] per;
    } strobe_t;

    strobe_t     strobe_q [$];
    logic [12:0] div_exp_q [$];
    int          clk4_cycles [$];

    int tests = 0;
    int fails = 0;
    int m_div = 0;
    bit m_sby_q = 1'b0;
    int cyc_n = 0;
    int tick_n = 0;
    int per_seen = 0;
    int obs_cnt [8];
    int first_seen [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic reset_stats();
        tick_n   = 0;
        per_seen = 0;
        for (int i = 0; i < 8; i++) begin
            obs_cnt[i]    = 0;
            first_seen[i] = 0;
        end
    endtask

    // One clock cycle: drive, predict, compare strobes mid-cycle and the count after the edge
    task automatic cyc(input logic c, input logic e, input logic r, input logic s);
        bit      tk;
        bit      rs;
        strobe_t ex;
        logic [12:0] dexp;
        @(negedge clk);
        ce_r  = c;
        en    = e;
        res_n = r;
        sby   = s;
        tk = c && e && r;
        rs = 1'b0;
`ifdef SH7604_PRESC_SBY_RESTART_EN
        rs = tk && m_sby_q && !s;
`endif
        ex = '0;
        for (int i = 0; i < 8; i++)
            if (tk && !rs && ((m_div + 1) % WDT_DIV[i] == 0)) ex.wdt[i] = 1'b1;
        for (int i = 0; i < 6; i++)
            if (tk && !rs && !s && ((m_div + 1) % PER_DIV[i] == 0)) ex.per[i] = 1'b1;
        strobe_q.push_back(ex);
        if (!r) begin
            m_div   = 0;
            m_sby_q = 1'b0;
        end else if (tk) begin
            m_div   = rs ? 0 : (m_div + 1) % 8192;
            m_sby_q = s;
        end
        div_exp_q.push_back(m_div[12:0]);
        #2;
        ex = strobe_q.pop_front();
        check("wdt_ce", 32'(wdt_ce), 32'(ex.wdt));
        check("per_ce", 32'(per_ce), 32'(ex.per));
        if (tk) tick_n++;
        cyc_n++;
        for (int i = 0; i < 8; i++) begin
            if (wdt_ce[i]) begin
                obs_cnt[i]++;
                if (first_seen[i] == 0) first_seen[i] = tick_n;
            end
        end
        if (|per_ce) per_seen++;
        if (per_ce[0]) clk4_cycles.push_back(cyc_n);
        @(posedge clk);
        #1;
        dexp = div_exp_q.pop_front();
        check("div_cnt", 32'(div_cnt), 32'(dexp));
    endtask

    initial begin
        int guard;
        rst   = 1'b1;
        ce_r  = 1'b0;
        en    = 1'b0;
        res_n = 1'b1;
        sby   = 1'b0;
        reset_stats();

        // Async reset held: everything zero even with enables active
        @(negedge clk);
        #1;
        check("rst_div", 32'(div_cnt), 32'd0);
        ce_r = 1'b1;
        en   = 1'b1;
        #1;
        check("rst_wdt", 32'(wdt_ce), 32'd0);
        check("rst_per", 32'(per_ce), 32'd0);
        @(posedge clk);
        #1;
        check("rst_div_held", 32'(div_cnt), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        ce_r = 1'b0;
        $display("[TB] reset released");

        // Full two-period run from reset
        reset_stats();
        repeat (16384) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        check("first_clk2", 32'(first_seen[0]), 32'd2);
        check("first_clk64", 32'(first_seen[1]), 32'd64);
        check("first_clk8192", 32'(first_seen[7]), 32'd8192);
        check("cnt_clk8192", 32'(obs_cnt[7]), 32'd2);
        check("cnt_clk4096", 32'(obs_cnt[6]), 32'd4);
        check("cnt_clk2", 32'(obs_cnt[0]), 32'd8192);
        check("wrap_div", 32'(div_cnt), 32'd0);
        $display("[TB] wrap run done: %0d CLK8192 pulses", obs_cnt[7]);

        // Sparse CE_R: CLK4 spacing stretches to 12 clocks
        reset_stats();
        clk4_cycles.delete();
        for (int i = 0; i < 60; i++) cyc((i % 3) == 0, 1'b1, 1'b1, 1'b0);
        check("clk4_seen", 32'(clk4_cycles.size() >= 3), 32'd1);
        for (int i = 1; i < clk4_cycles.size(); i++)
            check("clk4_period", 32'(clk4_cycles[i] - clk4_cycles[i-1]), 32'd12);
        $display("[TB] sparse CE_R done: %0d CLK4 pulses", clk4_cycles.size());

        // EN low and CE_R low freeze the count
        repeat (5) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        $display("[TB] freeze done at div=%0d", m_div);

        // Standby: WDT strobes continue, peripheral strobes gated
        reset_stats();
        repeat (500) cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check("sby_per_zero", 32'(per_seen), 32'd0);
        check("sby_clk128_3or4", 32'(obs_cnt[2] >= 3 && obs_cnt[2] <= 4), 32'd1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        $display("[TB] standby done: %0d CLK128 pulses", obs_cnt[2]);

        // RES_N pulse at DIV=1000
        guard = 0;
        while (m_div != 1000 && guard < 9000) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0);
            guard++;
        end
        check("reach_1000", 32'(div_cnt), 32'd1000);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("resn_div_zero", 32'(div_cnt), 32'd0);
        reset_stats();
        repeat (1024) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        check("resn_first_clk1024", 32'(first_seen[5]), 32'd1024);
        check("resn_cnt_clk1024", 32'(obs_cnt[5]), 32'd1);
        $display("[TB] res_n restart done");

        // Standby exit at DIV=100
        guard = 0;
        while (m_div != 99 && guard < 9000) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0);
            guard++;
        end
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check("sby_at_100", 32'(div_cnt), 32'd100);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        reset_stats();
`ifdef SH7604_PRESC_SBY_RESTART_EN
        check("sby_exit_div", 32'(div_cnt), 32'd0);
        repeat (4) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        check("sby_exit_clk2", 32'(first_seen[0]), 32'd2);
`else
        check("sby_exit_div", 32'(div_cnt), 32'd101);
        repeat (4) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        check("sby_exit_clk2", 32'(first_seen[0]), 32'd1);
`endif
        $display("[TB] standby exit done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
